// File: rtl/axis_packet_combiner_v2.sv
// AXI-Stream packet combiner: merges N input packets into one output packet behind a registered skid buffer.
// Optional statistics counters are built when AXIS_PACKET_COMBINER_STATS_EN is defined.
module axis_packet_combiner_v2 #(
  parameter int AXIS_TDATA_WIDTH     = 32,
  parameter int AXIS_TUSER_WIDTH     = 1,
  parameter int CNT_WIDTH            = 16,
  parameter int DEFAULT_PACKETS      = 256,
  parameter int DISCARD_FIRST_PACKET = 1
) (
  input  logic                          axis_aclk,
  input  logic                          axis_aresetn,
  input  logic [CNT_WIDTH-1:0]          cfg_packets,
  input  logic                          cfg_resync,
  output logic                          s_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                          s_axis_tvalid,
  input  logic                          s_axis_tlast,
  input  logic                          m_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic [AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  output logic                          synced_out
`ifdef AXIS_PACKET_COMBINER_STATS_EN
  ,
  output logic [31:0]                   stat_out_packets,
  output logic [31:0]                   stat_dropped_beats
`endif
);

  localparam int KEEP_WIDTH = AXIS_TDATA_WIDTH / 8;
  localparam logic [0:0] ST_UNSYNCED = 1'b0;
  localparam logic [0:0] ST_SYNCED   = 1'b1;

  logic [0:0]                  state, state_next;
  logic [CNT_WIDTH-1:0]        countdown, countdown_next, reload_val;
  logic                        accept, fwd, in_last;
  logic                        out_ready, out_load_skid, out_load_in;
  logic                        skid_load, skid_valid_next, out_valid_next, tready_next;

  logic                        skid_valid;
  logic [AXIS_TDATA_WIDTH-1:0] skid_data;
  logic [KEEP_WIDTH-1:0]       skid_keep;
  logic [AXIS_TUSER_WIDTH-1:0] skid_user;
  logic                        skid_last;

  assign synced_out = (state == ST_SYNCED);

  // A configured count of zero behaves as one packet per output packet.
  always_comb begin
    reload_val     = (cfg_packets == '0) ? '0 : cfg_packets - CNT_WIDTH'(1);
    accept         = s_axis_tvalid & s_axis_tready;
    fwd            = accept & (state == ST_SYNCED);
    in_last        = s_axis_tlast & (countdown == '0);
    state_next     = state;
    countdown_next = countdown;
    if (cfg_resync) begin
      state_next = ST_UNSYNCED;
    end else if (state == ST_UNSYNCED) begin
      if (accept && s_axis_tlast) begin
        state_next     = ST_SYNCED;
        countdown_next = reload_val;
      end
    end else if (accept && s_axis_tlast) begin
      if (countdown == '0) countdown_next = reload_val;
      else                 countdown_next = countdown - CNT_WIDTH'(1);
    end
  end

  // The skid slot only fills when the output register is stalled, so the
  // registered ready can be derived from next-cycle occupancy alone.
  always_comb begin
    out_ready       = ~m_axis_tvalid | m_axis_tready;
    out_load_skid   = out_ready & skid_valid;
    out_load_in     = out_ready & ~skid_valid & fwd;
    skid_load       = fwd & ~out_load_in;
    skid_valid_next = skid_load | (skid_valid & ~out_ready);
    out_valid_next  = out_ready ? (skid_valid | fwd) : 1'b1;
    tready_next     = (state_next == ST_UNSYNCED) | ~skid_valid_next;
  end

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state         <= (DISCARD_FIRST_PACKET != 0) ? ST_UNSYNCED : ST_SYNCED;
      countdown     <= CNT_WIDTH'(DEFAULT_PACKETS - 1);
      s_axis_tready <= 1'b1;
      skid_valid    <= 1'b0;
      m_axis_tvalid <= 1'b0;
    end else begin
      state         <= state_next;
      countdown     <= countdown_next;
      s_axis_tready <= tready_next;
      skid_valid    <= skid_valid_next;
      m_axis_tvalid <= out_valid_next;
    end
  end

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      skid_data    <= '0;
      skid_keep    <= '0;
      skid_user    <= '0;
      skid_last    <= 1'b0;
      m_axis_tdata <= '0;
      m_axis_tkeep <= '0;
      m_axis_tuser <= '0;
      m_axis_tlast <= 1'b0;
    end else begin
      if (skid_load) begin
        skid_data <= s_axis_tdata;
        skid_keep <= s_axis_tkeep;
        skid_user <= s_axis_tuser;
        skid_last <= in_last;
      end
      if (out_load_skid) begin
        m_axis_tdata <= skid_data;
        m_axis_tkeep <= skid_keep;
        m_axis_tuser <= skid_user;
        m_axis_tlast <= skid_last;
      end else if (out_load_in) begin
        m_axis_tdata <= s_axis_tdata;
        m_axis_tkeep <= s_axis_tkeep;
        m_axis_tuser <= s_axis_tuser;
        m_axis_tlast <= in_last;
      end
    end
  end

`ifdef AXIS_PACKET_COMBINER_STATS_EN
  // Saturating counters; only reset clears them.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      stat_out_packets   <= '0;
      stat_dropped_beats <= '0;
    end else begin
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast && (stat_out_packets != 32'hFFFF_FFFF))
        stat_out_packets <= stat_out_packets + 32'd1;
      if (accept && (state == ST_UNSYNCED) && (stat_dropped_beats != 32'hFFFF_FFFF))
        stat_dropped_beats <= stat_dropped_beats + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axis_packet_combiner_v2.sv
// Directed testbench for axis_packet_combiner_v2: sync drop, runtime N, N=0, random backpressure, resync, async reset.
// Stats ports are connected and checked when AXIS_PACKET_COMBINER_STATS_EN is defined.
module tb_axis_packet_combiner_v2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cfg_packets = 16'd4;
  logic        cfg_resync = 1'b0;
  logic        s_tready;
  logic [31:0] s_tdata = '0;
  logic [3:0]  s_tkeep = '0;
  logic [0:0]  s_tuser = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic        m_ready = 1'b1;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic [0:0]  m_tuser;
  logic        m_valid;
  logic        m_tlast;
  logic        synced;
`ifdef AXIS_PACKET_COMBINER_STATS_EN
  logic [31:0] stat_out_packets;
  logic [31:0] stat_dropped_beats;
`endif

  int checks = 0;
  int errors = 0;
  int stable_errs = 0;
  bit rand_ready = 1'b0;
  logic prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic prev_last = 1'b0;

  logic [31:0] got_data[$];
  logic        got_last[$];
  logic [3:0]  got_keep[$];
  logic        got_user[$];
  logic [31:0] exp_data[$];
  logic        exp_last[$];

  always #5 clk = ~clk;

  axis_packet_combiner_v2 dut (
    .axis_aclk     (clk),
    .axis_aresetn  (rst_n),
    .cfg_packets   (cfg_packets),
    .cfg_resync    (cfg_resync),
    .s_axis_tready (s_tready),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tuser  (s_tuser),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .m_axis_tready (m_ready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tuser  (m_tuser),
    .m_axis_tvalid (m_valid),
    .m_axis_tlast  (m_tlast),
    .synced_out    (synced)
`ifdef AXIS_PACKET_COMBINER_STATS_EN
    ,
    .stat_out_packets   (stat_out_packets),
    .stat_dropped_beats (stat_dropped_beats)
`endif
  );

  function automatic logic [3:0] keep_of(input logic [31:0] d);
    return d[3:0] ^ 4'b1010;
  endfunction

  function automatic logic user_of(input logic [31:0] d);
    return d[4];
  endfunction

  // Output monitor: records beats that will hand off at the next rising edge and checks stall stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!m_valid || m_tdata !== prev_data || m_tlast !== prev_last))
        stable_errs++;
      if (m_valid && m_ready) begin
        got_data.push_back(m_tdata);
        got_last.push_back(m_tlast);
        got_keep.push_back(m_tkeep);
        got_user.push_back(m_tuser[0]);
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_tdata;
      prev_last  = m_tlast;
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      m_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [31:0] d, input logic last, input logic exp_fwd, input logic exp_out_last);
    int budget = 0;
    @(negedge clk);
    s_tdata  = d;
    s_tkeep  = keep_of(d);
    s_tuser  = user_of(d);
    s_tlast  = last;
    s_tvalid = 1'b1;
    while (!s_tready && budget < 1000) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 1000) check_output("ready_timeout", {31'b0, s_tready}, 32'd1);
    @(posedge clk);
    if (exp_fwd) begin
      exp_data.push_back(d);
      exp_last.push_back(exp_out_last);
    end
  endtask

  task automatic send_packet(input int len, input logic [31:0] base, input logic exp_fwd, input logic exp_last_end);
    for (int i = 0; i < len; i++)
      apply_stimulus(base + 32'(i), (i == len - 1), exp_fwd, exp_last_end && (i == len - 1));
  endtask

  task automatic go_idle();
    @(negedge clk);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic pulse_resync();
    @(negedge clk);
    s_tvalid   = 1'b0;
    cfg_resync = 1'b1;
    @(negedge clk);
    cfg_resync = 1'b0;
  endtask

  task automatic clear_queues();
    got_data.delete(); got_last.delete(); got_keep.delete(); got_user.delete();
    exp_data.delete(); exp_last.delete();
  endtask

  task automatic drain_and_compare(input string tag);
    int budget = 0;
    int bad_d = 0, bad_l = 0, bad_k = 0, bad_u = 0;
    int n;
    go_idle();
    while (got_data.size() < exp_data.size() && budget < 5000) begin
      @(negedge clk);
      budget++;
    end
    repeat (4) @(negedge clk);
    check_output({tag, "_count"}, 32'(got_data.size()), 32'(exp_data.size()));
    n = (got_data.size() < exp_data.size()) ? got_data.size() : exp_data.size();
    for (int i = 0; i < n; i++) begin
      if (got_data[i] !== exp_data[i]) bad_d++;
      if (got_last[i] !== exp_last[i]) bad_l++;
      if (got_keep[i] !== keep_of(exp_data[i])) bad_k++;
      if (got_user[i] !== user_of(exp_data[i])) bad_u++;
    end
    check_output({tag, "_data_errs"}, 32'(bad_d), 32'd0);
    check_output({tag, "_tlast_errs"}, 32'(bad_l), 32'd0);
    check_output({tag, "_tkeep_errs"}, 32'(bad_k), 32'd0);
    check_output({tag, "_tuser_errs"}, 32'(bad_u), 32'd0);
    clear_queues();
  endtask

  initial begin
    // Reset state
    #12;
    check_output("rst_m_valid_async", {31'b0, m_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_output("rst_s_tready", {31'b0, s_tready}, 32'd1);
    check_output("rst_synced", {31'b0, synced}, 32'd0);
    check_output("rst_m_valid", {31'b0, m_valid}, 32'd0);
    check_output("rst_m_tlast", {31'b0, m_tlast}, 32'd0);
    check_output("rst_m_tdata", m_tdata, 32'd0);
    check_output("rst_m_tkeep", {28'b0, m_tkeep}, 32'd0);

    // N=4, partial first packet dropped, tlast every 16 beats
    $display("[TB] test 1: N=4 with partial first packet");
    cfg_packets = 16'd4;
    apply_stimulus(32'hA0, 1'b0, 1'b0, 1'b0);
    #1 check_output("t1_synced_before", {31'b0, synced}, 32'd0);
    apply_stimulus(32'hA1, 1'b1, 1'b0, 1'b0);
    #1 check_output("t1_synced_after", {31'b0, synced}, 32'd1);
    apply_stimulus(32'd1, 1'b0, 1'b1, 1'b0);
    #1 check_output("t1_latency_valid", {31'b0, m_valid}, 32'd1);
    check_output("t1_latency_data", m_tdata, 32'd1);
    check_output("t1_no_dropped_out", 32'(got_data.size()), 32'd0);
    for (int i = 1; i < 4; i++) apply_stimulus(32'(1 + i), (i == 3), 1'b1, 1'b0);
    for (int p = 1; p < 8; p++) send_packet(4, 32'(1 + 4 * p), 1'b1, (p % 4) == 3);
    drain_and_compare("t1");

    // N=3 then changed to 5 during the second input packet
    $display("[TB] test 2: N=3 then 5");
    cfg_packets = 16'd3;
    pulse_resync();
    check_output("t2_unsynced", {31'b0, synced}, 32'd0);
    apply_stimulus(32'hEE, 1'b1, 1'b0, 1'b0);
    send_packet(4, 32'd100, 1'b1, 1'b0);
    apply_stimulus(32'd104, 1'b0, 1'b1, 1'b0);
    cfg_packets = 16'd5;
    for (int i = 1; i < 4; i++) apply_stimulus(32'(104 + i), (i == 3), 1'b1, 1'b0);
    for (int p = 2; p < 8; p++) send_packet(4, 32'(100 + 4 * p), 1'b1, (p == 2) || (p == 7));
    drain_and_compare("t2");

    // N=0 behaves as N=1
    $display("[TB] test 3: N=0");
    cfg_packets = 16'd0;
    pulse_resync();
    apply_stimulus(32'hEF, 1'b1, 1'b0, 1'b0);
    send_packet(2, 32'd200, 1'b1, 1'b1);
    send_packet(1, 32'd210, 1'b1, 1'b1);
    send_packet(3, 32'd220, 1'b1, 1'b1);
    drain_and_compare("t3");

    // Random backpressure, continuous input, N=1
    $display("[TB] test 4: random m_axis_tready");
    stable_errs = 0;
    rand_ready = 1'b1;
    for (int p = 0; p < 50; p++) send_packet(4, 32'(1000 + 4 * p), 1'b1, 1'b1);
    drain_and_compare("t4");
    rand_ready = 1'b0;
    @(posedge clk);
    #2 m_ready = 1'b1;
    check_output("t4_stall_stable", 32'(stable_errs), 32'd0);

    // Resync in the middle of packet 2 of 4
    $display("[TB] test 5: resync mid-packet");
    cfg_packets = 16'd4;
    pulse_resync();
    apply_stimulus(32'hF0, 1'b1, 1'b0, 1'b0);
    send_packet(4, 32'd1, 1'b1, 1'b0);
    apply_stimulus(32'd5, 1'b0, 1'b1, 1'b0);
    apply_stimulus(32'd6, 1'b0, 1'b1, 1'b0);
    pulse_resync();
    check_output("t5_synced_gap", {31'b0, synced}, 32'd0);
    apply_stimulus(32'd7, 1'b0, 1'b0, 1'b0);
    #1 check_output("t5_synced_mid_gap", {31'b0, synced}, 32'd0);
    apply_stimulus(32'd8, 1'b1, 1'b0, 1'b0);
    #1 check_output("t5_resynced", {31'b0, synced}, 32'd1);
    for (int p = 0; p < 4; p++) send_packet(4, 32'(9 + 4 * p), 1'b1, p == 3);
    drain_and_compare("t5");

    // Async reset with a beat held in the output stage
    $display("[TB] test 6: reset mid-packet");
    m_ready = 1'b0;
    apply_stimulus(32'h99, 1'b0, 1'b0, 1'b0);
    #1 check_output("t6_held_valid", {31'b0, m_valid}, 32'd1);
    check_output("t6_held_data", m_tdata, 32'h99);
    go_idle();
    #2 rst_n = 1'b0;
    #1 check_output("t6_async_valid", {31'b0, m_valid}, 32'd0);
    check_output("t6_async_data", m_tdata, 32'd0);
    check_output("t6_async_synced", {31'b0, synced}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);
    check_output("t6_post_tready", {31'b0, s_tready}, 32'd1);
    check_output("t6_post_synced", {31'b0, synced}, 32'd0);
`ifdef AXIS_PACKET_COMBINER_STATS_EN
    check_output("t6_stat_packets", stat_out_packets, 32'd0);
    check_output("t6_stat_dropped", stat_dropped_beats, 32'd0);
`endif
    clear_queues();
    send_packet(2, 32'h300, 1'b0, 1'b0);
    #1 check_output("t6_resynced", {31'b0, synced}, 32'd1);
    for (int p = 0; p < 4; p++) send_packet(4, 32'(32'h400 + 4 * p), 1'b1, p == 3);
    drain_and_compare("t6");
`ifdef AXIS_PACKET_COMBINER_STATS_EN
    check_output("t6_stat_packets_after", stat_out_packets, 32'd1);
    check_output("t6_stat_dropped_after", stat_dropped_beats, 32'd2);
`endif
    check_output("t6_stall_stable", 32'(stable_errs), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
